// File: rtl/ysyx_22041412_icache_resp_if.sv
// Fetch/refill bundle for the instruction cache.
//   IFU side  : if_read_vaild, r_addr_i -> ready_o, r_data_o
//   fence     : fence_i -> fence_ready
//   refill    : mem_req, mem_addr -> mem_rvalid, mem_rdata, mem_rlast
//   counters  : hit_count, miss_count
// master = IFU / bus-bridge side, slave = cache.
interface ysyx_22041412_icache_resp_if #(
  parameter int ADDR_W = 32
);
  logic              if_read_vaild;
  logic [ADDR_W-1:0] r_addr_i;
  logic              ready_o;
  logic [31:0]       r_data_o;
  logic              fence_i;
  logic              fence_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              mem_rlast;
  logic [63:0]       hit_count;
  logic [63:0]       miss_count;

  modport master (
    output if_read_vaild, r_addr_i, fence_i, mem_rvalid, mem_rdata, mem_rlast,
    input  ready_o, r_data_o, fence_ready, mem_req, mem_addr, hit_count, miss_count
  );

  modport slave (
    input  if_read_vaild, r_addr_i, fence_i, mem_rvalid, mem_rdata, mem_rlast,
    output ready_o, r_data_o, fence_ready, mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/ysyx_22041412_icache_resp.sv
// Direct-mapped instruction cache with whole-line burst refill and
// FENCE.I invalidate-all.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of ysyx_22041412_icache_resp_if
//                (IFU fetch handshake, fence handshake, refill port,
//                 64-bit hit/miss counters)
module ysyx_22041412_icache_resp #(
  parameter int INDEX_W = 4,
  parameter int OFFS_W  = 2,
  parameter int ADDR_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ysyx_22041412_icache_resp_if.slave  bus
);

  localparam int NSETS      = 2 ** INDEX_W;
  localparam int LINE_WORDS = 2 ** OFFS_W;
  localparam int TAG_W      = ADDR_W - 2 - OFFS_W - INDEX_W;
  localparam logic [ADDR_W-1:0]  LINE_MASK = ~ADDR_W'(2 ** (OFFS_W + 2) - 1);
  localparam logic [INDEX_W-1:0] LAST_SET  = INDEX_W'(NSETS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_RESP,
    S_FENCE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0]  req_addr;
  logic [NSETS-1:0]   valid;
  logic [TAG_W-1:0]   tag_arr  [NSETS];
  logic [31:0]        data_arr [NSETS][LINE_WORDS];
  logic [OFFS_W-1:0]  beat_cnt;
  logic [INDEX_W-1:0] set_cnt;
  logic               fence_ready_q;
  logic               mem_req_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [63:0]        hit_cnt;
  logic [63:0]        miss_cnt;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [OFFS_W-1:0]  req_offs;
  logic               hit;
  logic               ready;
  logic [31:0]        sel_word;

  // Byte-offset bits of the fetch address carry no information.
  logic               unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = req_addr[2+OFFS_W +: INDEX_W];
  assign req_offs = req_addr[2 +: OFFS_W];
  assign hit      = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign sel_word = data_arr[req_idx][req_offs];

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.fence_i)            state_next = S_FENCE;
        else if (bus.if_read_vaild) state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          ready      = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_REFILL;
        end
      end
      S_REFILL: begin
        if (bus.mem_rvalid && bus.mem_rlast) state_next = S_RESP;
      end
      S_RESP: begin
        ready      = 1'b1;
        state_next = S_IDLE;
      end
      S_FENCE: begin
        if (set_cnt == LAST_SET) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      req_addr      <= '0;
      valid         <= '0;
      beat_cnt      <= '0;
      set_cnt       <= '0;
      fence_ready_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      state         <= state_next;
      fence_ready_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.fence_i)            set_cnt  <= '0;
          else if (bus.if_read_vaild) req_addr <= bus.r_addr_i;
        end
        S_LOOKUP: begin
          if (hit) begin
            hit_cnt <= hit_cnt + 64'd1;
          end else begin
            miss_cnt   <= miss_cnt + 64'd1;
            mem_req_q  <= 1'b1;
            mem_addr_q <= req_addr & LINE_MASK;
            beat_cnt   <= '0;
          end
        end
        S_REFILL: begin
          if (bus.mem_rvalid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (bus.mem_rlast) begin
              valid[req_idx] <= 1'b1;
              mem_req_q      <= 1'b0;
            end
          end
        end
        S_FENCE: begin
          valid[set_cnt] <= 1'b0;
          set_cnt        <= set_cnt + 1'b1;
          // fence_ready lands in the IDLE cycle after the final clear.
          if (set_cnt == LAST_SET) fence_ready_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Line storage is intentionally not reset; the valid bits gate it.
  always_ff @(posedge clk) begin
    if (state == S_REFILL && bus.mem_rvalid) begin
      data_arr[req_idx][beat_cnt] <= bus.mem_rdata;
      if (bus.mem_rlast) tag_arr[req_idx] <= req_tag;
    end
  end

  assign bus.ready_o     = ready;
  assign bus.r_data_o    = ready ? sel_word : '0;
  assign bus.fence_ready = fence_ready_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.hit_count   = hit_cnt;
  assign bus.miss_count  = miss_cnt;

endmodule

// File: doc/ysyx_22041412_icache_resp.md
Name: ysyx_22041412_icache_resp

Overview:
- Direct-mapped instruction cache that answers the IFU fetch handshake: request valid plus address in, one-cycle ready pulse plus instruction word out.
- On a miss, refills a whole line from a word-wide burst memory port.
- Services FENCE.I by walking and invalidating every set, then pulsing fence_ready.
- Sits between the IFU and the memory/bus bridge; also exports hit/miss performance counters.

Parameters:
- INDEX_W, 4, set index width (NSETS = 2**INDEX_W = 16 sets).
- OFFS_W, 2, word-offset width (LINE_WORDS = 4 words, i.e. 16-byte lines).
- ADDR_W, 32, address width. Tag = addr[ADDR_W-1 : 2+OFFS_W+INDEX_W].

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- if_read_vaild  in  1  IFU fetch request.
- r_addr_i  in  32  fetch address, word aligned; bits [1:0] ignored.
- ready_o  out  1  one-cycle pulse; r_data_o is valid in this cycle.
- r_data_o  out  32  instruction word; 0 whenever ready_o = 0.
- fence_i  in  1  invalidate-all request (level).
- fence_ready  out  1  one-cycle pulse when invalidation is complete.
- mem_req  out  1  refill request; held high until the last beat.
- mem_addr  out  32  line-aligned refill address, stable while mem_req = 1.
- mem_rvalid  in  1  refill beat valid.
- mem_rdata  in  32  refill beat data; beats arrive in ascending word order.
- mem_rlast  in  1  marks the final beat.
- hit_count  out  64  count of lookups that hit.
- miss_count  out  64  count of lookups that missed.

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to IDLE and all valid bits clear.
  - ready_o, fence_ready and mem_req are 0; r_data_o, mem_addr and both counters are 0.
  - Data and tag arrays are not reset.
  - Reset mid-refill or mid-fence aborts the operation. Beats arriving after reset are ignored because the state is IDLE.
- States: IDLE, LOOKUP, REFILL, RESP, FENCE.
- IDLE:
  - If fence_i = 1, clear the set counter and go to FENCE. Fence has priority over a simultaneous if_read_vaild.
  - Else if if_read_vaild = 1, register the address and go to LOOKUP.
  - if_read_vaild is ignored in every state except IDLE; the captured address is the request.
- LOOKUP:
  - Hit (valid bit set and tag equal): ready_o = 1 and r_data_o = the selected word, both combinational in this cycle. hit_count increments; next state is IDLE.
  - Hit latency is 1 cycle after acceptance, so back-to-back hits are accepted every 2 cycles.
  - Miss: miss_count increments. mem_req = 1 and mem_addr = {tag, index, OFFS_W+2 zero bits}, both registered at the LOOKUP-to-REFILL transition. Next state is REFILL.
- REFILL:
  - Each mem_rvalid writes mem_rdata into word beat_cnt of the set; beat_cnt increments.
  - On mem_rvalid & mem_rlast: write the tag, set the valid bit, drop mem_req, go to RESP.
  - mem_rlast before LINE_WORDS beats means the valid bit is still set; this is a protocol violation and the bench treats it as an error.
  - mem_rvalid outside REFILL is ignored.
- RESP: ready_o = 1 with the requested word read from the just-filled line; next state is IDLE. Miss latency is 2 + number of beat cycles.
- FENCE:
  - Clear one valid bit per cycle at set_cnt, for sets 0..NSETS-1.
  - After clearing set NSETS-1, fence_ready = 1 for one cycle (registered, the cycle after the last clear), then return to IDLE.
  - Total is NSETS+1 cycles from the IDLE cycle that saw fence_i. Fetch requests during FENCE are ignored.
  - fence_i still high on return to IDLE starts another fence. The IFU drops fence_i on fence_ready.
- Counters are 64-bit and wrap naturally. Exactly one of the two counters increments per LOOKUP.
- ready_o and fence_ready are never high together; ready_o is high in at most one cycle per request.

Test Plan:
- Cold miss:
  - Stimulus: reset, then valid with addr 0x80000004; memory returns 0x11,0x22,0x33,0x44 with rlast on the 4th beat.
  - Response: mem_addr = 0x80000000; ready_o pulses once in RESP with r_data_o = 0x22; miss_count = 1.
- Hit: then request 0x8000000C -> ready_o one cycle after acceptance, data 0x44, no mem_req, hit_count = 1.
- Conflict: request 0x80000100 (same index 0, different tag) -> miss and refill at 0x80000100; then 0x80000000 misses again; miss_count = 3.
- Fence:
  - Stimulus: fence_i asserted together with if_read_vaild in IDLE.
  - Response: fence wins; fence_ready pulses exactly 17 cycles later. A following request to 0x80000004 misses.
- Reset mid-refill: rst_n low after beat 2, beats 3-4 still presented -> after reset, mem_req = 0 and counters = 0; a request to the same line misses (valid bit clear).
- Idle noise: mem_rvalid pulses in IDLE, and valid toggles during REFILL -> no array change, no extra ready_o.
